// File: rtl/led_meter_pkg.sv
// Shared constants, peak-marker states and LED decode helpers
// for the LED VU meter.
package led_meter_pkg;

  localparam int unsigned NLED = 8;

  localparam logic [15:0] THRESH [0:NLED-1] = '{
    16'h0040, 16'h0080, 16'h0100, 16'h0200,
    16'h0400, 16'h0800, 16'h1000, 16'h2000
  };

  localparam logic [15:0] CLIP_THR = 16'h7000;

  typedef enum logic [1:0] {
    PK_IDLE,
    PK_HOLD,
    PK_FALL
  } pk_st_t;

  function automatic logic [NLED-1:0] therm(
    input logic [3:0] n
  );
    logic [NLED-1:0] t;
    t = '0;
    for (int i = 0; i < NLED; i++)
      t[i] = (4'(i) < n);
    return t;
  endfunction

  function automatic logic [NLED-1:0] onehot(
    input logic [3:0] n
  );
    logic [NLED-1:0] t;
    t = '0;
    for (int i = 0; i < NLED; i++)
      t[i] = (4'(i + 1) == n);
    return t;
  endfunction

endpackage

// File: rtl/lvl_quant.sv
// Magnitude to bar-length encoder: counts the thresholds
// the input level reaches (0..8).
module lvl_quant
  import led_meter_pkg::*;
(
  input  logic [15:0] lvl,
  output logic [3:0]  cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NLED; i++)
      if (lvl >= THRESH[i])
        cnt = cnt + 4'd1;
  end

endmodule

// File: rtl/led_vu_meter.sv
// LED bar-graph level meter with fast attack, stepped release,
// peak-hold marker and overload flag.
module led_vu_meter
  import led_meter_pkg::*;
#(
  parameter int unsigned DECAY_CYC = 3_125_000,
  parameter int unsigned HOLD_CYC  = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lvl_vld,
  input  logic [15:0] lvl,
  output logic [7:0]  led,
  output logic [7:0]  pk_led,
  output logic        ovr
);

  localparam int unsigned DW =
    (DECAY_CYC > 1) ? $clog2(DECAY_CYC) : 1;
  localparam int unsigned HW =
    (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [DW-1:0] D_END = DW'(DECAY_CYC - 1);
  localparam logic [HW-1:0] H_END = HW'(HOLD_CYC - 1);

  logic [3:0]    q;
  logic [3:0]    tgt, tgt_nxt;
  logic [3:0]    bar_cnt, bar_nxt;
  logic [DW-1:0] dcnt, dcnt_nxt;

  logic [3:0]    pk_pos, pk_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic [DW-1:0] pcnt, pcnt_nxt;
  pk_st_t        st, st_nxt;

  logic [HW-1:0] ocnt;
  logic          clip;

  lvl_quant u_quant (
    .lvl (lvl),
    .cnt (q)
  );

  assign clip = lvl_vld && (lvl >= CLIP_THR);

  // attack beats a coincident release step
  always_comb begin
    tgt_nxt  = tgt;
    bar_nxt  = bar_cnt;
    dcnt_nxt = dcnt;
    if (lvl_vld)
      tgt_nxt = q;
    if (lvl_vld && (q >= bar_cnt)) begin
      bar_nxt  = q;
      dcnt_nxt = '0;
    end else if (bar_cnt > tgt) begin
      if (dcnt == D_END) begin
        bar_nxt  = bar_cnt - 4'd1;
        dcnt_nxt = '0;
      end else begin
        dcnt_nxt = dcnt + DW'(1);
      end
    end else begin
      dcnt_nxt = '0;
    end
  end

  always_comb begin
    st_nxt   = st;
    pk_nxt   = pk_pos;
    hcnt_nxt = hcnt;
    pcnt_nxt = '0;
    if (bar_nxt > pk_pos) begin
      pk_nxt   = bar_nxt;
      hcnt_nxt = '0;
      st_nxt   = PK_HOLD;
    end else begin
      unique case (st)
        PK_IDLE: ;
        PK_HOLD: begin
          if (hcnt == H_END)
            st_nxt = PK_FALL;
          else
            hcnt_nxt = hcnt + HW'(1);
        end
        PK_FALL: begin
          if ((pk_pos == bar_cnt) || (pk_pos == 4'd0))
            st_nxt = PK_IDLE;
          else if (pcnt == D_END)
            pk_nxt = pk_pos - 4'd1;
          else
            pcnt_nxt = pcnt + DW'(1);
        end
        default: st_nxt = PK_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt     <= '0;
      bar_cnt <= '0;
      dcnt    <= '0;
      pk_pos  <= '0;
      hcnt    <= '0;
      pcnt    <= '0;
      st      <= PK_IDLE;
    end else begin
      tgt     <= tgt_nxt;
      bar_cnt <= bar_nxt;
      dcnt    <= dcnt_nxt;
      pk_pos  <= pk_nxt;
      hcnt    <= hcnt_nxt;
      pcnt    <= pcnt_nxt;
      st      <= st_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr  <= 1'b0;
      ocnt <= '0;
    end else if (clip) begin
      ovr  <= 1'b1;
      ocnt <= '0;
    end else if (ovr) begin
      if (ocnt == H_END)
        ovr <= 1'b0;
      else
        ocnt <= ocnt + HW'(1);
    end
  end

  assign led    = therm(bar_cnt);
  assign pk_led = onehot(pk_pos);

endmodule

// File: tb/tb_led_vu_meter.sv
// Directed bench for led_vu_meter at DECAY_CYC=4, HOLD_CYC=10;
// inputs change and outputs are sampled on the falling edge.
module tb_led_vu_meter;

  logic        clk;
  logic        rst;
  logic        lvl_vld;
  logic [15:0] lvl;
  logic [7:0]  led;
  logic [7:0]  pk_led;
  logic        ovr;

  int n_chk;
  int n_err;

  led_vu_meter #(
    .DECAY_CYC (4),
    .HOLD_CYC  (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .lvl_vld (lvl_vld),
    .lvl     (lvl),
    .led     (led),
    .pk_led  (pk_led),
    .ovr     (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bar8(input int n);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    return t[7:0];
  endfunction

  function automatic logic [7:0] pk8(input int n);
    logic [8:0] t;
    t = (n == 0) ? 9'd0 : (9'd1 << (n - 1));
    return t[7:0];
  endfunction

  task automatic strobe(input logic [15:0] v);
    lvl     = v;
    lvl_vld = 1'b1;
    @(negedge clk);
    lvl_vld = 1'b0;
  endtask

  task automatic rst_seq();
    rst     = 1'b1;
    lvl_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int eb, ep;
    n_chk   = 0;
    n_err   = 0;
    rst     = 1'b1;
    lvl_vld = 1'b0;
    lvl     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    repeat (20) begin
      lvl     = 16'($urandom);
      lvl_vld = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    rst     = 1'b1;
    lvl_vld = 1'b1;
    lvl     = 16'h7FFF;
    repeat (2) @(negedge clk);
    chk("rst_led", led, 8'h00);
    chk("rst_pk", pk_led, 8'h00);
    chk("rst_ovr", {7'd0, ovr}, 8'h00);
    rst     = 1'b0;
    lvl_vld = 1'b0;
    @(negedge clk);
    chk("post_rst_led", led, 8'h00);
    chk("post_rst_pk", pk_led, 8'h00);

    strobe(16'h0300);
    chk("atk_led", led, 8'h0F);
    chk("atk_pk", pk_led, 8'h08);
    chk("atk_ovr", {7'd0, ovr}, 8'h00);
    strobe(16'h0000);
    for (int k = 1; k <= 28; k++) begin
      eb = (k < 5) ? 4 : 4 - (k - 1) / 4;
      if (eb < 0) eb = 0;
      ep = (k < 14) ? 4 : 4 - (k - 10) / 4;
      if (ep < 0) ep = 0;
      chk($sformatf("rel_led_k%0d", k), led, bar8(eb));
      chk($sformatf("rel_pk_k%0d", k), pk_led, pk8(ep));
      @(negedge clk);
    end

    strobe(16'h7FFF);
    chk("clip_led", led, 8'hFF);
    chk("clip_pk", pk_led, 8'h80);
    chk("clip_ovr", {7'd0, ovr}, 8'h01);
    for (int k = 1; k <= 10; k++) begin
      lvl = (k % 2 == 1) ? 16'h0000 : 16'h7FFF;
      @(negedge clk);
      chk($sformatf("nov_led_k%0d", k), led, 8'hFF);
      chk($sformatf("nov_pk_k%0d", k), pk_led, 8'h80);
      chk($sformatf("ovr_k%0d", k), {7'd0, ovr},
          (k < 10) ? 8'h01 : 8'h00);
    end

    rst_seq();
    strobe(16'h003F);
    chk("q_3f", led, 8'h00);
    strobe(16'h0040);
    chk("q_40", led, 8'h01);
    strobe(16'h1FFF);
    chk("q_1fff", led, 8'h7F);
    strobe(16'h2000);
    chk("q_2000", led, 8'hFF);
    chk("q_2000_ovr", {7'd0, ovr}, 8'h00);
    strobe(16'h6FFF);
    chk("q_6fff_ovr", {7'd0, ovr}, 8'h00);
    strobe(16'h7000);
    chk("q_7000_ovr", {7'd0, ovr}, 8'h01);
    chk("q_7000_pk", pk_led, 8'h80);

    rst_seq();
    strobe(16'h0400);
    chk("f_atk_led", led, 8'h1F);
    chk("f_atk_pk", pk_led, 8'h10);
    strobe(16'h0000);
    repeat (10) @(negedge clk);
    chk("f_fall_pk", pk_led, 8'h10);
    chk("f_fall_led", led, 8'h07);
    strobe(16'h1800);
    chk("f_re_led", led, 8'h7F);
    chk("f_re_pk", pk_led, 8'h40);
    strobe(16'h0000);
    repeat (12) @(negedge clk);
    chk("f_hold_pk", pk_led, 8'h40);
    chk("f_hold_led", led, 8'h0F);
    @(negedge clk);
    chk("f_drop_pk", pk_led, 8'h20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
